// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobing, frame debounce, multi-key rejection, valid/ready key events.
// Optional auto-repeat while a key is held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 20,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       key_overrun,
  output logic       multi_key
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  logic [3:0]       fila_s1_reg, fila_s2_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [3:0]       col_reg;
  logic [1:0]       col_idx_reg;
  logic             acc_any_reg, acc_bad_reg;
  logic [3:0]       acc_code_reg;
  state_t           state_reg, state_next;
  logic [3:0]       cand_reg, cand_next;
  logic [DEB_W-1:0] deb_cnt_reg, deb_next, deb_inc;
  logic [3:0]       key_code_reg;
  logic             key_valid_reg, key_overrun_reg;

  logic       sample_tick, frame_end, transfer, accept;
  logic [1:0] row_idx;
  logic       samp_any, cur_any, cur_bad;
  logic [3:0] cur_code;
  logic       frm_none, frm_bad, frm_valid;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_V = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RATE_V  = REP_W'(REPEAT_RATE);
  logic [REP_W-1:0] rep_cnt_reg, rep_next, rep_inc;
  logic             rep_first_reg, rep_first_next;
  assign rep_inc = rep_cnt_reg + REP_W'(1);
`else
  // Keeps the repeat parameters referenced when no repeat logic exists.
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
`endif

  assign sample_tick = (div_cnt_reg == DIV_LAST);
  assign frame_end   = sample_tick && (col_idx_reg == 2'd3);
  assign transfer    = key_valid_reg && key_ready;
  assign deb_inc     = deb_cnt_reg + DEB_W'(1);

  // Fold the current column sample into the running frame judgement.
  always_comb begin
    row_idx = 2'd0;
    case (fila_s2_reg)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    samp_any = |fila_s2_reg;
    cur_any  = acc_any_reg | samp_any;
    cur_bad  = acc_bad_reg | (samp_any & (acc_any_reg | !$onehot(fila_s2_reg)));
    cur_code = samp_any ? {col_idx_reg, row_idx} : acc_code_reg;
  end

  assign frm_none  = frame_end && !cur_any;
  assign frm_bad   = frame_end && cur_any && cur_bad;
  assign frm_valid = frame_end && cur_any && !cur_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fila_s1_reg  <= '0;
      fila_s2_reg  <= '0;
      div_cnt_reg  <= '0;
      col_reg      <= 4'b0001;
      col_idx_reg  <= 2'd0;
      acc_any_reg  <= 1'b0;
      acc_bad_reg  <= 1'b0;
      acc_code_reg <= '0;
    end else begin
      fila_s1_reg <= fila;
      fila_s2_reg <= fila_s1_reg;
      if (sample_tick) begin
        div_cnt_reg <= '0;
        col_reg     <= {col_reg[2:0], col_reg[3]};
        col_idx_reg <= col_idx_reg + 2'd1;
        if (col_idx_reg == 2'd3) begin
          acc_any_reg  <= 1'b0;
          acc_bad_reg  <= 1'b0;
          acc_code_reg <= '0;
        end else begin
          acc_any_reg  <= cur_any;
          acc_bad_reg  <= cur_bad;
          acc_code_reg <= cur_code;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    deb_next   = deb_cnt_reg;
    accept     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_next       = rep_cnt_reg;
    rep_first_next = rep_first_reg;
`endif
    if (frame_end) begin
      case (state_reg)
        IDLE: if (frm_valid) begin
          cand_next = cur_code;
          if (DEBOUNCE_FRAMES == 1) begin
            accept     = 1'b1;
            state_next = HELD;
            deb_next   = '0;
          end else begin
            state_next = CONFIRM;
            deb_next   = DEB_W'(1);
          end
        end
        CONFIRM: begin
          if (!frm_valid) begin
            state_next = IDLE;
            deb_next   = '0;
          end else if (cur_code != cand_reg) begin
            cand_next = cur_code;
            deb_next  = DEB_W'(1);
          end else if (deb_inc == DEB_TARGET) begin
            accept     = 1'b1;
            state_next = HELD;
            deb_next   = '0;
          end else begin
            deb_next = deb_inc;
          end
        end
        HELD: begin
          if (frm_none) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_next = IDLE;
              deb_next   = '0;
            end else begin
              state_next = RELEASE;
              deb_next   = DEB_W'(1);
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else begin
            rep_next = rep_inc;
            if (rep_inc == (rep_first_reg ? REP_DELAY_V : REP_RATE_V)) begin
              accept         = 1'b1;
              rep_next       = '0;
              rep_first_next = 1'b0;
            end
          end
`endif
        end
        RELEASE: begin
          if (!frm_none) begin
            state_next = HELD;
            deb_next   = '0;
          end else if (deb_inc == DEB_TARGET) begin
            state_next = IDLE;
            deb_next   = '0;
          end else begin
            deb_next = deb_inc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    // Repeat timing restarts from scratch whenever the key leaves HELD.
    if (state_next != HELD) begin
      rep_next       = '0;
      rep_first_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cand_reg        <= '0;
      deb_cnt_reg     <= '0;
      key_code_reg    <= '0;
      key_valid_reg   <= 1'b0;
      key_overrun_reg <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg     <= '0;
      rep_first_reg   <= 1'b1;
`endif
    end else begin
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      deb_cnt_reg <= deb_next;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg   <= rep_next;
      rep_first_reg <= rep_first_next;
`endif
      // A same-cycle transfer frees the slot, so the new event loads instead of overrunning.
      if (accept && (!key_valid_reg || transfer)) begin
        key_code_reg  <= cand_next;
        key_valid_reg <= 1'b1;
      end else if (transfer) begin
        key_valid_reg <= 1'b0;
      end
      if (transfer) begin
        key_overrun_reg <= 1'b0;
      end else if (accept && key_valid_reg) begin
        key_overrun_reg <= 1'b1;
      end
    end
  end

  assign col         = col_reg;
  assign key_code    = key_code_reg;
  assign key_valid   = key_valid_reg;
  assign key_overrun = key_overrun_reg;
  assign key_held    = (state_reg == HELD) || (state_reg == RELEASE);
  assign multi_key   = frm_bad;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Frame-by-frame directed test of keypad_scan_ctrl with a behavioural 4x4 key matrix.
module tb_keypad_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] fila;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       key_overrun;
  logic       multi_key;
  logic [15:0] key_mask = 16'h0000;

  int total = 0;
  int bad = 0;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk(clk), .rst_n(rst_n), .fila(fila), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held),
    .key_overrun(key_overrun), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Key matrix: bit {c,r} of key_mask shorts column c to row r.
  always_comb begin
    fila = 4'b0000;
    for (int c = 0; c < 4; c++)
      if (col[c])
        for (int r = 0; r < 4; r++)
          if (key_mask[c*4+r]) fila[r] = 1'b1;
  end

  typedef struct {
    logic [15:0] mask;
    logic        rdy;
    logic        valid;
    logic [3:0]  code;
    logic        held;
    logic        ovr;
    int          multi;
  } vec_t;

  vec_t vecs[$];

  localparam logic [15:0] K0 = 16'h0001, K3 = 16'h0008, K6 = 16'h0040, K9 = 16'h0200;
  localparam logic [15:0] K15 = 16'h8000, M2 = 16'h8001, IV = 16'h0030, NK = 16'h0000;

  task automatic add(input logic [15:0] m, input logic r, input logic v, input logic [3:0] c,
                     input logic h, input logic o, input int mk, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{m, r, v, c, h, o, mk});
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0d want=%0d", name, row, act, exp);
    end
  endtask

  // Called at the first cycle of a frame; returns at the first cycle of the next one.
  task automatic run_frame(input int idx);
    int mcnt;
    mcnt = 0;
    key_mask  = vecs[idx].mask;
    key_ready = vecs[idx].rdy;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (multi_key) mcnt++;
    end
    $display("row %0d mask=%h rdy=%b valid=%b code=%h held=%b ovr=%b multi=%0d",
             idx, vecs[idx].mask, vecs[idx].rdy, key_valid, key_code, key_held, key_overrun, mcnt);
    chk("valid", idx, int'(key_valid), int'(vecs[idx].valid));
    chk("code", idx, int'(key_code), int'(vecs[idx].code));
    chk("held", idx, int'(key_held), int'(vecs[idx].held));
    chk("overrun", idx, int'(key_overrun), int'(vecs[idx].ovr));
    chk("multi", idx, mcnt, vecs[idx].multi);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) run_frame(i);
  endtask

  task automatic chk_reset_state(input int tag);
    chk("rst_col", tag, int'(col), 1);
    chk("rst_valid", tag, int'(key_valid), 0);
    chk("rst_code", tag, int'(key_code), 0);
    chk("rst_held", tag, int'(key_held), 0);
    chk("rst_overrun", tag, int'(key_overrun), 0);
    chk("rst_multi", tag, int'(multi_key), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int m_a, m_b, m_c, m_d, m_e;
    // Single press: accept on 3rd frame, release after 3 empty frames.
    add(K6, 1, 0, 4'h0, 0, 0, 0, 2);
    add(K6, 1, 1, 4'h6, 1, 0, 0, 1);
    add(K6, 1, 0, 4'h6, 1, 0, 0, 2);
    add(NK, 1, 0, 4'h6, 1, 0, 0, 2);
    add(NK, 1, 0, 4'h6, 0, 0, 0, 2);
    // Bounce: VALID, NONE, then three VALID frames.
    add(K3, 1, 0, 4'h6, 0, 0, 0, 1);
    add(NK, 1, 0, 4'h6, 0, 0, 0, 1);
    add(K3, 1, 0, 4'h6, 0, 0, 0, 2);
    add(K3, 1, 1, 4'h3, 1, 0, 0, 1);
    add(NK, 1, 0, 4'h3, 1, 0, 0, 2);
    add(NK, 1, 0, 4'h3, 0, 0, 0, 1);
    // Two keys in different columns, then one column with two rows.
    add(M2, 1, 0, 4'h3, 0, 0, 1, 5);
    add(NK, 1, 0, 4'h3, 0, 0, 0, 1);
    add(K6, 1, 0, 4'h3, 0, 0, 0, 1);
    add(IV, 1, 0, 4'h3, 0, 0, 1, 1);
    add(K6, 1, 0, 4'h3, 0, 0, 0, 2);
    add(K6, 1, 1, 4'h6, 1, 0, 0, 1);
    // Held: other key and invalid frames do not roll over; bounce during release.
    add(K9, 1, 0, 4'h6, 1, 0, 0, 2);
    add(IV, 1, 0, 4'h6, 1, 0, 1, 1);
    add(NK, 1, 0, 4'h6, 1, 0, 0, 1);
    add(K9, 1, 0, 4'h6, 1, 0, 0, 1);
    add(NK, 1, 0, 4'h6, 1, 0, 0, 2);
    add(NK, 1, 0, 4'h6, 0, 0, 0, 1);
    // Consumer stalled: second press is dropped.
    add(K0, 0, 0, 4'h6, 0, 0, 0, 2);
    add(K0, 0, 1, 4'h0, 1, 0, 0, 1);
    add(NK, 0, 1, 4'h0, 1, 0, 0, 2);
    add(NK, 0, 1, 4'h0, 0, 0, 0, 1);
    add(K15, 0, 1, 4'h0, 0, 0, 0, 2);
    add(K15, 0, 1, 4'h0, 1, 1, 0, 1);
    add(NK, 0, 1, 4'h0, 1, 1, 0, 2);
    add(NK, 0, 1, 4'h0, 0, 1, 0, 1);
    m_a = vecs.size();
    // Pending event, then a second one completing as the first is taken.
    add(K9, 0, 0, 4'h0, 0, 0, 0, 2);
    add(K9, 0, 1, 4'h9, 1, 0, 0, 1);
    add(NK, 0, 1, 4'h9, 1, 0, 0, 2);
    add(NK, 0, 1, 4'h9, 0, 0, 0, 1);
    add(K6, 0, 1, 4'h9, 0, 0, 0, 2);
    m_b = vecs.size();
    add(NK, 1, 0, 4'h6, 1, 0, 0, 2);
    add(NK, 1, 0, 4'h6, 0, 0, 0, 1);
    add(K6, 1, 0, 4'h6, 0, 0, 0, 2);
    m_c = vecs.size();
    // After reset the held key needs three fresh frames.
    add(K6, 1, 0, 4'h0, 0, 0, 0, 2);
    add(K6, 1, 1, 4'h6, 1, 0, 0, 1);
    add(K6, 1, 0, 4'h6, 1, 0, 0, 1);
    m_d = vecs.size();
    m_e = m_d;

    repeat (3) @(negedge clk);
    chk_reset_state(-1);
    rst_n = 1'b1;

    run_rows(0, m_a);

    // Raising ready takes the pending event and clears the overrun flag.
    key_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid", m_a, int'(key_valid), 0);
    chk("hs_overrun", m_a, int'(key_overrun), 0);
    chk("hs_code", m_a, int'(key_code), 0);
    $display("handshake valid=%b ovr=%b code=%h", key_valid, key_overrun, key_code);
    key_ready = 1'b0;
    repeat (15) @(negedge clk);

    run_rows(m_a, m_b);

    // Ready only on the evaluation cycle: transfer and accept coincide.
    key_mask  = K6;
    key_ready = 1'b0;
    repeat (15) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    chk("sim_valid", m_b, int'(key_valid), 1);
    chk("sim_code", m_b, int'(key_code), 6);
    chk("sim_overrun", m_b, int'(key_overrun), 0);
    chk("sim_held", m_b, int'(key_held), 1);
    $display("simultaneous valid=%b ovr=%b code=%h", key_valid, key_overrun, key_code);

    run_rows(m_b, m_c - 2);
    run_rows(m_c - 2, m_c);

    // Reset in CONFIRM with the key still held.
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_state(m_c);
    $display("reset mid-confirm col=%b valid=%b held=%b", col, key_valid, key_held);
    repeat (2) @(negedge clk);
    chk_reset_state(m_c + 1);
    rst_n = 1'b1;

    run_rows(m_c, m_e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
